// File: rtl/fwd_pkg.sv
// Shared select encodings, stage-record type and tag-match helper for the
// forwarding / hazard unit.
package fwd_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  localparam int STORE_SRC  = 1;
  // Records carry tags at this fixed width so one struct serves every REG_AW.
  localparam int MAX_REG_AW = 8;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] dst;
    logic                  regWrite;
    logic                  isLoad;
  } stageRec_t;

  function automatic logic recMatch(input stageRec_t rec,
                                    input logic [MAX_REG_AW-1:0] src,
                                    input logic zeroRegEn);
    return rec.valid & rec.regWrite & (rec.dst == src) &
           (~zeroRegEn | (rec.dst != '0));
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-source resolution: EX/MEM select, load-use hazard, or load-to-store
// data forward deferred to the MEM stage.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_AW       = 4,
  parameter bit ZERO_REG_EN  = 1'b1,
  parameter bit IS_STORE_SRC = 1'b0
) (
  input  logic [REG_AW-1:0] src,
  input  logic              srcActive,
  input  logic              idIsStore,
  input  stageRec_t         exRec,
  input  stageRec_t         memRec,
  output logic [1:0]        sel,
  output logic              hazard,
  output logic              storeFwd
);

  logic [MAX_REG_AW-1:0] srcExt;
  logic                  exHit;
  logic                  memHit;

  assign srcExt = MAX_REG_AW'(src);
  assign exHit  = srcActive & recMatch(exRec, srcExt, ZERO_REG_EN);
  assign memHit = srcActive & recMatch(memRec, srcExt, ZERO_REG_EN);

  always_comb begin
    sel      = FWD_RF;
    hazard   = 1'b0;
    storeFwd = 1'b0;
    if (exHit) begin
      if (!exRec.isLoad) begin
        sel = FWD_EXMEM;
      end else if (IS_STORE_SRC && idIsStore) begin
        // Store data is only needed in MEM, by which time the load is in WB.
        storeFwd = 1'b1;
      end else begin
        hazard = 1'b1;
      end
    end else if (memHit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Stateful forwarding and hazard unit: tracks EX/MEM/WB destination tags,
// registers operand selects, inserts load-use bubbles and counts stalls.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int NUM_SRC     = 2,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_reg_write,
  input  logic                      id_is_load,
  input  logic                      id_is_store,
  input  logic                      mem_busy,
  output logic                      stall_id,
  output logic                      freeze,
  output logic [2*NUM_SRC-1:0]      ex_fwd_sel,
  output logic                      mem_store_fwd,
  output logic [CNT_W-1:0]          stall_cnt
);

  stageRec_t exRec;
  stageRec_t memRec;
  stageRec_t wbRec;
  stageRec_t idRec;

  logic [2*NUM_SRC-1:0] selVec;
  logic [NUM_SRC-1:0]   hazardVec;
  logic [NUM_SRC-1:0]   storeVec;
  logic                 exStoreFlag;

  assign idRec = '{valid: id_valid, dst: MAX_REG_AW'(id_dst),
                   regWrite: id_reg_write, isLoad: id_is_load};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : gSrc
      fwd_src_match #(
        .REG_AW      (REG_AW),
        .ZERO_REG_EN (ZERO_REG_EN),
        .IS_STORE_SRC(gi == STORE_SRC)
      ) uMatch (
        .src      (id_src[gi*REG_AW +: REG_AW]),
        .srcActive(id_valid & id_src_used[gi]),
        .idIsStore(id_is_store),
        .exRec    (exRec),
        .memRec   (memRec),
        .sel      (selVec[2*gi +: 2]),
        .hazard   (hazardVec[gi]),
        .storeFwd (storeVec[gi])
      );
    end
  endgenerate

  assign freeze   = mem_busy;
  assign stall_id = (|hazardVec) & ~mem_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exRec         <= '0;
      memRec        <= '0;
      wbRec         <= '0;
      ex_fwd_sel    <= '0;
      exStoreFlag   <= 1'b0;
      mem_store_fwd <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      if (!mem_busy) begin
        memRec        <= exRec;
        wbRec         <= memRec;
        mem_store_fwd <= exStoreFlag;
        if (stall_id) begin
          exRec       <= '0;
          ex_fwd_sel  <= '0;
          exStoreFlag <= 1'b0;
        end else begin
          exRec       <= idRec;
          ex_fwd_sel  <= selVec;
          exStoreFlag <= |storeVec;
        end
      end
      if ((stall_id | freeze) && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised, stateful forwarding and hazard unit for the pipelined core; the successor to the combinational forwarding logic. It tracks its own copy of destination tags for the EX, MEM and WB stages. From these it produces registered EX-stage operand selects and a registered MEM-stage store-data forward. It also detects load-use hazards and inserts exactly one bubble per hazard, freezes the pipe while data memory is busy, and keeps a saturating stall counter.

## Interface
Parameters:
- REG_AW, 4, register-specifier width
- NUM_SRC, 2, source operands per instruction; source index 1 is store data
- ZERO_REG_EN, 1, when 1 register 0 never matches (hard-wired zero)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  instruction in ID is real (not a bubble)
- id_src  in  NUM_SRC*REG_AW  source specifiers; source s at bits [s*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  per-source read enable
- id_dst  in  REG_AW  destination specifier
- id_reg_write  in  1  instruction writes a register
- id_is_load  in  1  instruction is a load
- id_is_store  in  1  instruction is a store
- mem_busy  in  1  data memory not ready; freezes all stages
- stall_id  out  1  hold PC and IF/ID, insert bubble into ID/EX
- freeze  out  1  hold every pipeline register (equals mem_busy)
- ex_fwd_sel  out  2*NUM_SRC  per-source EX operand select: 0 regfile, 1 EX/MEM, 2 MEM/WB
- mem_store_fwd  out  1  store in MEM takes data from the MEM/WB result
- stall_cnt  out  CNT_W  cycles with stall_id or freeze asserted, saturating

## Operation
- Internal stage records for EX, MEM and WB, each holding {valid, dst, reg_write, is_load}. A record matches when valid & reg_write & dst==src, with dst!=0 additionally required if ZERO_REG_EN.
- Per source s, evaluated in ID when id_valid & id_src_used[s]:
  - EX record matches and EX is not a load: sel = 1.
  - EX record matches, EX is a load, and (s==1 & id_is_store): no stall; set pending store-forward flag.
  - EX record matches, EX is a load, any other case: load-use hazard; stall_id = 1.
  - Otherwise MEM record matches: sel = 2.
  - Otherwise: sel = 0.
  - The youngest stage always wins.
- stall_id is the OR of load-use hazards over all sources. It is combinational and gated low while freeze is asserted.
- Advance (freeze=0, stall_id=0):
  - ID becomes the EX record.
  - ex_fwd_sel loads the computed selects.
  - EX→MEM and MEM→WB shift.
  - The pending store-forward flag moves to an EX-stage flag; that flag moves to mem_store_fwd on the next advance.
- Stall (freeze=0, stall_id=1):
  - EX record loads valid=0.
  - ex_fwd_sel loads 0 and the EX store flag loads 0.
  - MEM and WB shift normally.
- Freeze (freeze=1): every register holds.
- WB-to-ID hazards are not forwarded; the register file write-through covers them.
- stall_cnt increments by 1 when stall_id|freeze, and holds at all-ones.

## Timing
- Reset (async, rst_n low):
  - All stage valids, ex_fwd_sel, both store flags and mem_store_fwd reset to 0.
  - stall_cnt resets to 0.
  - stall_id = 0 while all valids are 0.
- ex_fwd_sel and mem_store_fwd are registered: valid for the whole cycle the instruction occupies EX / MEM. Latency is 1 cycle from ID evaluation.
- A load-use hazard gives exactly 1 stall cycle. On the next cycle the load is in MEM, the consumer re-evaluates with sel=2, and stall_id deasserts.
- mem_busy concurrent with a hazard: freeze dominates, nothing moves, and the hazard persists until unfrozen. stall_cnt counts that cycle once.
- Reset deasserted mid-stream: the first instruction sees empty stages, so sel=0 and no stall.

## Structure
- Package fwd_pkg: FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2, the stage-record struct, and the STORE_SRC=1 constant.
- Sub-module fwd_src_match: one instance per source (generate loop). Takes the source specifier plus the EX and MEM records; returns sel, hazard and store-forward flag.
- Top level: stage-record registers, stall/freeze control, stall counter.

## Test plan
- ADD r3 ← r1,r2 then SUB r4 ← r3,r5 → the cycle SUB is in EX: ex_fwd_sel[1:0]=1, ex_fwd_sel[3:2]=0, no stall.
- LW r3 then ADD r6 ← r3,r3 → stall_id=1 for one cycle, then ex_fwd_sel=4'b1010, stall_cnt=1.
- LW r7 then SW r7 → no stall; mem_store_fwd=1 the cycle SW is in MEM; ex_fwd_sel[3:2]=0.
- ADD r0 ← … then use r0 with ZERO_REG_EN=1 → sel=0. ADD r2 in MEM and ADD r2 in EX, then use r2 → sel=1 (youngest wins).
- Load-use hazard with mem_busy=1 for 3 cycles → all outputs hold, stall_id=0 during freeze, stall_cnt=4 after the single stall resolves.
- Assert rst_n low mid-stall → all outputs 0 immediately, without waiting for clk; after release, first instruction sel=0.
